fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and assembles a 16-bit instruction from two 8-bit reads,
// low byte first, then offers it downstream over a valid/ready handshake.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        E,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_rvalid,
  input  logic        pc_load,
  input  logic [15:0] pc_load_value,
  output logic [15:0] PC,
  output logic [15:0] IR,
  output logic        ir_valid,
  input  logic        ir_ready
);

  typedef enum logic [1:0] {
    S_FLUSH = 2'd0,
    S_LO    = 2'd1,
    S_HI    = 2'd2,
    S_VALID = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        valid_q, valid_d;
  logic        req_q, req_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    if (E) begin
      // Redirect wins over everything, including a same-cycle memory response.
      if (pc_load) begin
        pc_d    = pc_load_value;
        valid_d = 1'b0;
        state_d = S_FLUSH;
      end else begin
        case (state_q)
          S_FLUSH: state_d = S_LO;
          S_LO: begin
            if (mem_rvalid) begin
              ir_d[7:0] = mem_rdata;
              pc_d      = pc_q + 16'd1;
              state_d   = S_HI;
            end
          end
          S_HI: begin
            if (mem_rvalid) begin
              ir_d[15:8] = mem_rdata;
              pc_d       = pc_q + 16'd1;
              valid_d    = 1'b1;
              state_d    = S_VALID;
            end
          end
          S_VALID: begin
            if (ir_ready) begin
              valid_d = 1'b0;
              state_d = S_LO;
            end
          end
          default: state_d = S_FLUSH;
        endcase
      end
    end
    // Request is derived from the next state so it stays a registered output.
    req_d = (state_d == S_LO) || (state_d == S_HI);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_FLUSH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  assign mem_req  = req_q;
  assign mem_addr = pc_q;
  assign PC       = pc_q;
  assign IR       = ir_q;
  assign ir_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: byte memory model plus a reference that predicts each
// instruction as {mem[a+1], mem[a]} over a 16-bit wrapping address stream.
module tb_fetch_unit;

  logic        Clock, Reset, E;
  logic        mem_req, mem_rvalid;
  logic [15:0] mem_addr, PC, IR, pc_load_value;
  logic [7:0]  mem_rdata;
  logic        pc_load, ir_valid, ir_ready;

  logic        w_E, w_mem_req, w_mem_rvalid, w_pc_load, w_ir_valid, w_ir_ready;
  logic [15:0] w_mem_addr, w_PC, w_IR, w_pc_load_value;
  logic [7:0]  w_mem_rdata;

  logic [7:0]  mem [0:65535];
  int checks, errors;

  fetch_unit u_dut (
    .Clock(Clock), .Reset(Reset), .E(E), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .pc_load(pc_load),
    .pc_load_value(pc_load_value), .PC(PC), .IR(IR), .ir_valid(ir_valid), .ir_ready(ir_ready)
  );

  fetch_unit #(.RESET_PC(16'hFFFF)) u_wrap (
    .Clock(Clock), .Reset(Reset), .E(w_E), .mem_req(w_mem_req), .mem_addr(w_mem_addr),
    .mem_rdata(w_mem_rdata), .mem_rvalid(w_mem_rvalid), .pc_load(w_pc_load),
    .pc_load_value(w_pc_load_value), .PC(w_PC), .IR(w_IR), .ir_valid(w_ir_valid),
    .ir_ready(w_ir_ready)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (!Reset && E && mem_rvalid)
      assert (mem_req) else $error("protocol: mem_rvalid without mem_req");
    if (!Reset && w_E && w_mem_rvalid)
      assert (w_mem_req) else $error("protocol: wrap mem_rvalid without mem_req");
  end

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic mem_drive(input bit allow);
    mem_rvalid = allow && E && mem_req && !Reset;
    mem_rdata  = mem_rvalid ? mem[mem_addr] : 8'($urandom);
  endtask

  task automatic w_drive();
    w_mem_rvalid = w_E && w_mem_req && !Reset;
    w_mem_rdata  = w_mem_rvalid ? mem[w_mem_addr] : 8'($urandom);
  endtask

  function automatic logic [15:0] instr_at(input logic [15:0] a);
    logic [15:0] a1;
    a1 = a + 16'd1;
    return {mem[a1], mem[a]};
  endfunction

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) tick();
    checks += 4;
    if (PC !== 16'h0000) begin errors++; $display("FAIL rst_pc got %h want 0000", PC); end
    if (IR !== 16'h0000) begin errors++; $display("FAIL rst_ir got %h want 0000", IR); end
    if (ir_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", ir_valid); end
    if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", mem_req); end
    Reset = 1'b0;
    ir_ready = 1'b1;
    // Cycle 1 after release is the idle flush; ir_valid shows in cycle 4.
    for (int k = 1; k <= 3; k++) begin
      mem_drive(1'b1);
      tick();
      checks += 3;
      if (ir_valid !== (k == 3)) begin errors++; $display("FAIL lat_valid[%0d] got %b want %b", k, ir_valid, (k == 3)); end
      if (mem_req !== (k < 3)) begin errors++; $display("FAIL lat_req[%0d] got %b want %b", k, mem_req, (k < 3)); end
      if (PC !== 16'(k - 1)) begin errors++; $display("FAIL lat_pc[%0d] got %h want %h", k, PC, 16'(k - 1)); end
    end
    checks++;
    if (IR !== 16'h1234) begin errors++; $display("FAIL first_ir got %h want 1234", IR); end
    ir_ready = 1'b0;
  endtask

  task automatic test_stall();
    for (int k = 0; k < 10; k++) begin
      mem_drive(1'b1);
      tick();
      checks++;
      if (IR !== 16'h1234 || mem_req !== 1'b0 || PC !== 16'h0002 || ir_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall[%0d] got ir=%h req=%b pc=%h v=%b want 1234 0 0002 1", k, IR, mem_req, PC, ir_valid);
      end
    end
    ir_ready = 1'b1;
    mem_drive(1'b1);
    tick();
    ir_ready = 1'b0;
    checks++;
    if (ir_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0002) begin
      errors++;
      $display("FAIL stall_resume got v=%b req=%b addr=%h want 0 1 0002", ir_valid, mem_req, mem_addr);
    end
    repeat (2) begin mem_drive(1'b1); tick(); end
    checks++;
    if (IR !== instr_at(16'h0002) || PC !== 16'h0004 || ir_valid !== 1'b1) begin
      errors++;
      $display("FAIL second_ir got %h pc=%h want %h pc=0004", IR, PC, instr_at(16'h0002));
    end
  endtask

  task automatic test_redirect();
    logic [7:0] hi_before;
    ir_ready = 1'b1;
    mem_drive(1'b1); tick();
    ir_ready = 1'b0;
    mem_drive(1'b1); tick();
    hi_before = IR[15:8];
    pc_load = 1'b1;
    pc_load_value = 16'h0100;
    mem_drive(1'b1);
    checks++;
    if (mem_rvalid !== 1'b1) begin errors++; $display("FAIL redir_setup got rvalid=%b want 1", mem_rvalid); end
    tick();
    pc_load = 1'b0;
    checks += 3;
    if (PC !== 16'h0100) begin errors++; $display("FAIL redir_pc got %h want 0100", PC); end
    if (IR !== {hi_before, mem[16'h0004]}) begin errors++; $display("FAIL redir_ir got %h want %h", IR, {hi_before, mem[16'h0004]}); end
    if (mem_req !== 1'b0 || ir_valid !== 1'b0) begin errors++; $display("FAIL redir_idle got req=%b v=%b want 0 0", mem_req, ir_valid); end
    mem_drive(1'b1); tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0100) begin errors++; $display("FAIL redir_req got req=%b addr=%h want 1 0100", mem_req, mem_addr); end
    repeat (2) begin mem_drive(1'b1); tick(); end
    checks++;
    if (ir_valid !== 1'b1 || IR !== instr_at(16'h0100) || PC !== 16'h0102) begin
      errors++;
      $display("FAIL redir_ir2 got v=%b ir=%h pc=%h want 1 %h 0102", ir_valid, IR, PC, instr_at(16'h0100));
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a;
    a = 16'h0102;
    ir_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      mem_drive(1'b1);
      tick();
      checks++;
      if (ir_valid !== (k % 3 == 0)) begin errors++; $display("FAIL b2b_valid[%0d] got %b want %b", k, ir_valid, (k % 3 == 0)); end
      if (k % 3 == 0) begin
        checks++;
        if (IR !== instr_at(a) || PC !== a + 16'd2) begin
          errors++;
          $display("FAIL b2b_ir[%0d] got %h pc=%h want %h pc=%h", k, IR, PC, instr_at(a), a + 16'd2);
        end
        a = a + 16'd2;
      end
    end
    ir_ready = 1'b0;
  endtask

  task automatic test_wait_enable();
    logic [15:0] ir_before;
    pc_load = 1'b1;
    pc_load_value = 16'h2000;
    mem_drive(1'b1); tick();
    pc_load = 1'b0;
    checks++;
    if (ir_valid !== 1'b0 || PC !== 16'h2000) begin errors++; $display("FAIL we_redir got v=%b pc=%h want 0 2000", ir_valid, PC); end
    mem_drive(1'b1); tick();
    mem_drive(1'b0); tick();
    ir_before = IR;
    E = 1'b0;
    pc_load = 1'b1;
    pc_load_value = 16'h5555;
    for (int k = 0; k < 2; k++) begin
      mem_drive(1'b1);
      tick();
      checks++;
      if (PC !== 16'h2000 || mem_addr !== 16'h2000 || IR !== ir_before || mem_req !== 1'b1 || ir_valid !== 1'b0) begin
        errors++;
        $display("FAIL we_frozen[%0d] got pc=%h addr=%h ir=%h req=%b want 2000 2000 %h 1", k, PC, mem_addr, IR, mem_req, ir_before);
      end
    end
    E = 1'b1;
    pc_load = 1'b0;
    mem_drive(1'b0); tick();
    checks++;
    if (mem_addr !== 16'h2000 || mem_req !== 1'b1) begin errors++; $display("FAIL we_wait got addr=%h req=%b want 2000 1", mem_addr, mem_req); end
    mem_drive(1'b1); tick();
    checks++;
    if (PC !== 16'h2001) begin errors++; $display("FAIL we_lo got pc=%h want 2001", PC); end
    mem_drive(1'b1); tick();
    checks++;
    if (ir_valid !== 1'b1 || IR !== instr_at(16'h2000) || PC !== 16'h2002) begin
      errors++;
      $display("FAIL we_ir got v=%b ir=%h pc=%h want 1 %h 2002", ir_valid, IR, PC, instr_at(16'h2000));
    end
  endtask

  task automatic test_random();
    logic [15:0] a, prev_ir;
    logic        prev_valid, xfer, redir;
    int          n, cyc;
    a = 16'($urandom);
    pc_load = 1'b1;
    pc_load_value = a;
    mem_drive(1'b1); tick();
    pc_load = 1'b0;
    n = 0;
    cyc = 0;
    while (n < 20 && cyc < 3000) begin
      cyc++;
      E = ($urandom % 8) != 0;
      ir_ready = $urandom % 2;
      redir = ($urandom % 24) == 0;
      pc_load = redir;
      pc_load_value = 16'($urandom);
      if (redir) ir_ready = 1'b0;
      mem_drive(($urandom % 3) != 0);
      xfer = ir_valid && ir_ready && E;
      prev_valid = ir_valid;
      prev_ir = IR;
      tick();
      if (xfer) begin
        checks++;
        if (prev_ir !== instr_at(a)) begin errors++; $display("FAIL rand_xfer[%0d] got %h want %h", n, prev_ir, instr_at(a)); end
        a = a + 16'd2;
        n++;
      end else if (prev_valid && !(redir && E)) begin
        checks++;
        if (ir_valid !== 1'b1 || IR !== prev_ir) begin errors++; $display("FAIL rand_hold got v=%b ir=%h want 1 %h", ir_valid, IR, prev_ir); end
      end
      if (redir && E) a = pc_load_value;
    end
    checks++;
    if (n < 20) begin errors++; $display("FAIL rand_timeout got %0d transfers want 20", n); end
    E = 1'b1;
    pc_load = 1'b0;
    ir_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    pc_load = 1'b1;
    pc_load_value = 16'h0300;
    mem_drive(1'b1); tick();
    pc_load = 1'b0;
    repeat (2) begin mem_drive(1'b1); tick(); end
    checks++;
    if (mem_req !== 1'b1 || PC !== 16'h0301) begin errors++; $display("FAIL ar_setup got req=%b pc=%h want 1 0301", mem_req, PC); end
    mem_drive(1'b1);
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (PC !== 16'h0000 || IR !== 16'h0000 || ir_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL ar_immediate got pc=%h ir=%h v=%b req=%b want 0000 0000 0 0", PC, IR, ir_valid, mem_req);
    end
    @(negedge Clock);
    Reset = 1'b0;
    mem_rvalid = 1'b0;
    mem_drive(1'b1); tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin errors++; $display("FAIL ar_restart got req=%b addr=%h want 1 0000", mem_req, mem_addr); end
    repeat (2) begin mem_drive(1'b1); tick(); end
    checks++;
    if (ir_valid !== 1'b1 || IR !== 16'h1234 || PC !== 16'h0002) begin
      errors++;
      $display("FAIL ar_ir got v=%b ir=%h pc=%h want 1 1234 0002", ir_valid, IR, PC);
    end
  endtask

  task automatic test_wrap();
    E = 1'b0;
    mem[16'hFFFF] = 8'hCD;
    mem[16'h0000] = 8'hAB;
    checks++;
    if (w_PC !== 16'hFFFF || w_mem_req !== 1'b0) begin errors++; $display("FAIL wrap_rst got pc=%h req=%b want ffff 0", w_PC, w_mem_req); end
    w_E = 1'b1;
    w_ir_ready = 1'b0;
    w_drive(); tick();
    checks++;
    if (w_mem_req !== 1'b1 || w_mem_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_lo got req=%b addr=%h want 1 ffff", w_mem_req, w_mem_addr); end
    w_drive(); tick();
    checks++;
    if (w_PC !== 16'h0000 || w_mem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_pc got pc=%h addr=%h want 0000 0000", w_PC, w_mem_addr); end
    w_drive(); tick();
    checks++;
    if (w_ir_valid !== 1'b1 || w_IR !== 16'hABCD || w_PC !== 16'h0001) begin
      errors++;
      $display("FAIL wrap_ir got v=%b ir=%h pc=%h want 1 abcd 0001", w_ir_valid, w_IR, w_PC);
    end
    w_E = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset = 1'b1;
    E = 1'b1;
    pc_load = 1'b0;
    pc_load_value = '0;
    ir_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    w_E = 1'b0;
    w_pc_load = 1'b0;
    w_pc_load_value = '0;
    w_ir_ready = 1'b0;
    w_mem_rvalid = 1'b0;
    w_mem_rdata = '0;
    for (int unsigned i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h34;
    mem[1] = 8'h12;
    test_reset();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_wait_enable();
    test_random();
    test_async_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
